lr35902_oam_dma: RTL and testbench
==================================

# lr35902_oam_dma

OAM DMA controller for the video subsystem. It copies 160 bytes from a CPU-selected source page into OAM, one byte per M-cycle (4 `clk`), after a write to the DMA register (FF46). It sits upstream of the OAM arbiter and the external-bus read path. Its outputs are `active`, `drv_ext`, the source read port (address, strobe, data in) and the OAM write port (address, strobe, data out).

## Interface
Parameters:
- `START_DELAY`, default 4: cycles between the detected register write and the first byte slot.
- `LEN`, default 160: bytes per transfer.

Ports:
- `clk`  in  1  4 MiHz system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `reg_din`  in  8  CPU data for FF46.
- `reg_write`  in  1  level write strobe for FF46, already qualified by decoding; may stay high for several cycles.
- `reg_dout`  out  8  last page written to FF46.
- `active`  out  1  transfer in progress, including the start delay.
- `drv_ext`  out  1  the block is driving the external address and `n_read` pins.
- `adr_rd`  out  16  source address.
- `read`  out  1  source read strobe.
- `data_in`  in  8  source read data.
- `adr_wr`  out  8  OAM byte index, 0..159.
- `write`  out  1  OAM write strobe.
- `data_out`  out  8  OAM write data.

## Operation
- **Start:** a transfer starts on the rising edge of `reg_write`, i.e. high now, low in the previous cycle. A held strobe counts as one start.
- **Latching:** on start, the block latches `page = reg_din` and updates `reg_dout`. The effective page is `page - 0x20` when `page >= 0xE0` (echo-RAM mirror); otherwise it is `page`.
- **States:**
  - IDLE -> DELAY on start.
  - DELAY -> XFER after `START_DELAY` cycles.
  - XFER -> IDLE after the phase-3 cycle of byte `LEN-1`.
  - A start in DELAY or XFER re-enters DELAY with the new page and resets the index to 0. `active` stays high throughout.
- **XFER per-byte slot:** 2-bit phase counter, byte index `i` (8 bits).
  - Phases 0-2: `adr_rd = {effpage, i}`, `read = 1`.
  - End of phase 2: `data_in` is registered into `data_out`.
  - Phase 3: `write = 1`, `adr_wr = i`, `read = 0`. Then `i` increments.
- **drv_ext:** equals `active && effpage not in 0x80..0x9F`. VRAM sources are read internally, so the external bus is not driven for them.
- **Idle outputs:** `read = write = 0`; `adr_rd`, `adr_wr` and `data_out` hold their last values.

## Timing
- **Reset values:** `active = drv_ext = read = write = 0`, `reg_dout = 0xFF`, `adr_rd = 0x0000`, `adr_wr = 0x00`, `data_out = 0x00`. State is IDLE, index 0, phase 0.
- **Assertion:** if the edge is sampled at cycle t, `active` and `drv_ext` are high from t+1.
  - Slot i occupies cycles t+1+`START_DELAY`+4i through +3.
  - `active` falls after cycle t+`START_DELAY`+4·`LEN`, which is t+644 at the defaults.
- **Source read latency:** `data_in` must be valid at the end of phase 2, which is 3 cycles after `adr_rd` becomes valid.
- **Mid-transfer rewrite:** the in-flight byte is abandoned; `write` is never asserted for it. The next `clk` enters DELAY.
- **Asynchronous reset:** `reset` mid-transfer drops `write`, `read`, `active` and `drv_ext` immediately, without waiting for a clock edge.
- **Boundaries:**
  - The index wraps only via the state transition; `adr_wr` never exceeds `LEN-1`.
  - Page 0xFF maps to 0xDF00..0xDF9F.

## Structure
- **Shared package `lr35902_pkg`:** `OAM_DMA_LEN = 160`, `OAM_DMA_START_DELAY = 4`, `ECHO_BASE = 8'hE0`, `ECHO_OFFSET = 8'h20`, `VRAM_PAGE_LO = 8'h80`, `VRAM_PAGE_HI = 8'h9F`, and the state enum (IDLE/DELAY/XFER).
- **Sub-module:** one, `lr35902_dma_slot`. It holds the 2-bit phase counter plus the byte index, and outputs the phase decode and last-byte flag. The top block keeps the FSM, page register and edge detector.

## Test plan
- Reset, then write 0xC0 once:
  - `active` high for 644 cycles.
  - Every write phase puts `data_out = mem[0xC000+i]` at `adr_wr = i`, for i = 0..159.
  - `drv_ext = 1`; `reg_dout = 0xC0`.
- Write 0x80:
  - Reads cover 0x8000..0x809F.
  - `drv_ext = 0` throughout while `active = 1`.
- Write 0xFE:
  - `adr_rd` spans 0xDE00..0xDE9F; `reg_dout = 0xFE`.
- Hold `reg_write` high for 10 cycles with 0xC1:
  - Exactly one transfer.
  - Exactly 160 write strobes.
- Write 0xC0, then at byte 50 phase 1 write 0xD0:
  - No write for byte 50 of 0xC0.
  - Restart with DELAY.
  - 160 bytes from 0xD000; `active` never drops.
- Assert `reset` at byte 80 phase 3:
  - `write`, `active` and `drv_ext` go to 0 with no clock.
  - After release, `reg_dout = 0xFF` and the block stays idle.

Source files
------------

// File: rtl/lr35902_pkg.sv
// lr35902_pkg: shared constants, state type and page helpers for the LR35902 OAM DMA
package lr35902_pkg;
  localparam int OAM_DMA_LEN = 160;
  localparam int OAM_DMA_START_DELAY = 4;
  localparam logic [7:0] ECHO_BASE = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET = 8'h20;
  localparam logic [7:0] VRAM_PAGE_LO = 8'h80;
  localparam logic [7:0] VRAM_PAGE_HI = 8'h9F;
  typedef enum logic [1:0] {IDLE, DELAY, XFER} dma_state_e;
  function automatic logic [7:0] eff_page(input logic [7:0] page);
    return page >= ECHO_BASE ? page - ECHO_OFFSET : page;
  endfunction
  function automatic logic is_vram(input logic [7:0] page);
    return page >= VRAM_PAGE_LO && page <= VRAM_PAGE_HI;
  endfunction
endpackage

// File: rtl/lr35902_oam_dma_if.sv
// lr35902_oam_dma_if: register, source-read and OAM-write signals of the OAM DMA
interface lr35902_oam_dma_if;
  logic [7:0] reg_din;
  logic reg_write;
  logic [7:0] reg_dout;
  logic active;
  logic drv_ext;
  logic [15:0] adr_rd;
  logic read;
  logic [7:0] data_in;
  logic [7:0] adr_wr;
  logic write;
  logic [7:0] data_out;
  modport master(input reg_din, reg_write, data_in,
                 output reg_dout, active, drv_ext, adr_rd, read, adr_wr, write, data_out);
  modport slave(output reg_din, reg_write, data_in,
                input reg_dout, active, drv_ext, adr_rd, read, adr_wr, write, data_out);
endinterface

// File: rtl/lr35902_dma_slot.sv
// lr35902_dma_slot: 4-phase byte slot counter and byte index for the OAM DMA
module lr35902_dma_slot
  import lr35902_pkg::*;
#(
  parameter int LEN = OAM_DMA_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] idx_o,
  output logic       rd_ph_o,
  output logic       cap_ph_o,
  output logic       wr_ph_o,
  output logic       last_o
);
  logic [1:0] ph_q, ph_d;
  logic [7:0] idx_q, idx_d;
  assign idx_o = idx_q;
  assign rd_ph_o = ph_q != 2'd3;
  assign cap_ph_o = ph_q == 2'd2;
  assign wr_ph_o = ph_q == 2'd3;
  assign last_o = wr_ph_o && idx_q == 8'(LEN - 1);
  // advance the phase every cycle; the index steps after the write phase and wraps after the last byte
  always_comb begin
    ph_d = clr_i ? 2'd0 : en_i ? ph_q + 2'd1 : ph_q;
    idx_d = clr_i || (en_i && last_o) ? 8'd0 : en_i && wr_ph_o ? idx_q + 8'd1 : idx_q;
  end
  // slot state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q <= 2'd0;
      idx_q <= 8'd0;
    end else begin
      ph_q <= ph_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/lr35902_oam_dma.sv
// lr35902_oam_dma: copies LEN bytes from a CPU-selected page into OAM after a write to FF46
module lr35902_oam_dma
  import lr35902_pkg::*;
#(
  parameter int START_DELAY = OAM_DMA_START_DELAY,
  parameter int LEN = OAM_DMA_LEN
) (
  input logic clk,
  input logic reset,
  lr35902_oam_dma_if.master bus
);
  dma_state_e state_q, state_d;
  logic [7:0] dly_q, dly_d, page_q, page_d, adr_wr_q, adr_wr_d, data_out_q, data_out_d;
  logic [15:0] adr_rd_q, adr_rd_d;
  logic reg_write_q, start, xfer, rd_en, wr_en, rd_ph, cap_ph, wr_ph, last;
  logic [7:0] idx, eff;
  assign start = bus.reg_write && !reg_write_q;
  assign xfer = state_q == XFER;
  assign eff = eff_page(page_q);
  assign rd_en = xfer && rd_ph;
  assign wr_en = xfer && wr_ph && !start;
  lr35902_dma_slot #(.LEN(LEN)) u_slot (
    .clk(clk),
    .reset(reset),
    .clr_i(start),
    .en_i(xfer),
    .idx_o(idx),
    .rd_ph_o(rd_ph),
    .cap_ph_o(cap_ph),
    .wr_ph_o(wr_ph),
    .last_o(last)
  );
  // a new start always re-enters DELAY; DELAY counts START_DELAY cycles; XFER ends after the last write phase
  always_comb begin
    state_d = state_q;
    dly_d = dly_q;
    if (start) begin
      state_d = DELAY;
      dly_d = 8'd0;
    end else if (state_q == DELAY) begin
      state_d = dly_q == 8'(START_DELAY - 1) ? XFER : DELAY;
      dly_d = dly_q + 8'd1;
    end else if (xfer && last) begin
      state_d = IDLE;
    end
  end
  // page latch and bus outputs that hold their last value while not transferring
  always_comb begin
    page_d = start ? bus.reg_din : page_q;
    adr_rd_d = rd_en ? {eff, idx} : adr_rd_q;
    adr_wr_d = wr_en ? idx : adr_wr_q;
    data_out_d = xfer && cap_ph ? bus.data_in : data_out_q;
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q <= 8'd0;
      page_q <= 8'hFF;
      reg_write_q <= 1'b0;
      adr_rd_q <= 16'h0000;
      adr_wr_q <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      state_q <= state_d;
      dly_q <= dly_d;
      page_q <= page_d;
      reg_write_q <= bus.reg_write;
      adr_rd_q <= adr_rd_d;
      adr_wr_q <= adr_wr_d;
      data_out_q <= data_out_d;
    end
  end
  assign bus.reg_dout = page_q;
  assign bus.active = state_q != IDLE;
  assign bus.drv_ext = bus.active && !is_vram(eff);
  assign bus.adr_rd = adr_rd_d;
  assign bus.read = rd_en;
  assign bus.adr_wr = adr_wr_d;
  assign bus.write = wr_en;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb_lr35902_oam_dma: directed self-checking bench for the OAM DMA controller
module tb_lr35902_oam_dma;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  lr35902_oam_dma_if bus();
  lr35902_oam_dma dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a[15:8] ^ 8'hA5) + a[7:0];
  endfunction
  function automatic logic [7:0] exp_eff(input logic [7:0] p);
    return p >= 8'hE0 ? p - 8'h20 : p;
  endfunction
  function automatic logic exp_drv(input logic [7:0] e);
    return !(e >= 8'h80 && e <= 8'h9F);
  endfunction
  assign bus.data_in = mem(bus.adr_rd);
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [7:0] page, input int hold, input int rs_n,
                     input logic [7:0] rs_page, input int exp_act, input int exp_wr);
    logic [7:0] p;
    logic [15:0] lo, hi;
    int wc, wtot, act, rd_err, drv_err, first_rd, n;
    p = page;
    lo = 16'hFFFF;
    hi = 16'h0000;
    wc = 0;
    wtot = 0;
    act = 0;
    rd_err = 0;
    drv_err = 0;
    first_rd = 0;
    n = 0;
    bus.reg_din = page;
    bus.reg_write = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (!bus.active) break;
      act++;
      if (bus.drv_ext !== exp_drv(exp_eff(p))) drv_err++;
      if (bus.read) begin
        if (first_rd == 0) first_rd = n;
        if (bus.adr_rd !== {exp_eff(p), 8'(wc)}) rd_err++;
        if (bus.adr_rd < lo) lo = bus.adr_rd;
        if (bus.adr_rd > hi) hi = bus.adr_rd;
      end
      if (bus.write) begin
        check({tag, "_adr_wr"}, int'(bus.adr_wr), wc);
        check({tag, "_data"}, int'(bus.data_out), int'(mem({exp_eff(p), 8'(wc)})));
        wc++;
        wtot++;
      end
      if (n >= hold) bus.reg_write = 1'b0;
      if (n == rs_n) begin
        bus.reg_din = rs_page;
        bus.reg_write = 1'b1;
        p = rs_page;
        wc = 0;
        lo = 16'hFFFF;
        hi = 16'h0000;
      end
    end
    bus.reg_write = 1'b0;
    check({tag, "_timeout"}, int'(n < 3000), 1);
    check({tag, "_active_cycles"}, act, exp_act);
    check({tag, "_writes"}, wtot, exp_wr);
    check({tag, "_rd_addr_err"}, rd_err, 0);
    check({tag, "_drv_err"}, drv_err, 0);
    check({tag, "_first_rd"}, first_rd, 5);
    check({tag, "_rd_lo"}, int'(lo), int'({exp_eff(p), 8'h00}));
    check({tag, "_rd_hi"}, int'(hi), int'({exp_eff(p), 8'h9F}));
    check({tag, "_reg_dout"}, int'(bus.reg_dout), int'(p));
    check({tag, "_adr_wr_hold"}, int'(bus.adr_wr), 159);
    check({tag, "_data_hold"}, int'(bus.data_out), int'(mem({exp_eff(p), 8'h9F})));
    check({tag, "_idle_rw"}, int'({bus.read, bus.write}), 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int act;
    bus.reg_din = 8'h00;
    bus.reg_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_active", int'(bus.active), 0);
    check("rst_drv_ext", int'(bus.drv_ext), 0);
    check("rst_read", int'(bus.read), 0);
    check("rst_write", int'(bus.write), 0);
    check("rst_reg_dout", int'(bus.reg_dout), 8'hFF);
    check("rst_adr_rd", int'(bus.adr_rd), 0);
    check("rst_adr_wr", int'(bus.adr_wr), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run("c0", 8'hC0, 1, 0, 8'h00, 644, 160);
    run("p80", 8'h80, 1, 0, 8'h00, 644, 160);
    run("pfe", 8'hFE, 1, 0, 8'h00, 644, 160);
    run("pff", 8'hFF, 1, 0, 8'h00, 644, 160);
    run("hold", 8'hC1, 10, 0, 8'h00, 644, 160);
    run("rewr", 8'hC0, 1, 206, 8'hD0, 850, 210);
    bus.reg_din = 8'hC0;
    bus.reg_write = 1'b1;
    for (int n = 1; n <= 328; n++) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
    end
    check("rs_pre_write", int'(bus.write), 1);
    check("rs_pre_adr_wr", int'(bus.adr_wr), 80);
    reset = 1'b1;
    #1;
    check("rs_write", int'(bus.write), 0);
    check("rs_read", int'(bus.read), 0);
    check("rs_active", int'(bus.active), 0);
    check("rs_drv_ext", int'(bus.drv_ext), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rs_reg_dout", int'(bus.reg_dout), 8'hFF);
    act = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      act += int'(bus.active) + int'(bus.write) + int'(bus.read);
    end
    check("rs_stays_idle", act, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
